// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory block-copy engine: default widths and
// the 2-bit FSM state encoding, also used by benches to decode dbgState.
package mem_copy_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory port bundle between the copy engine (master) and the single-port
// data memory (slave).
//
// Port semantics: there is no valid/ready handshake on this port. The master
// presents memAddress every cycle; with memWriteEnable=1 the memory stores
// memDataIn at memAddress on the rising edge. The memory always registers
// mem[memAddress] onto memDataOut at the rising edge, so read data is valid
// in the cycle after the address was presented.
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memDataIn;
  logic                  memWriteEnable;
  logic [DATA_WIDTH-1:0] memDataOut;

  modport master (
    output memAddress,
    output memDataIn,
    output memWriteEnable,
    input  memDataOut
  );

  modport slave (
    input  memAddress,
    input  memDataIn,
    input  memWriteEnable,
    output memDataOut
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the 16-bit single-port data memory. Reads `length`
// words from srcAddr upward and writes them to dstAddr upward, one word every
// two cycles (READ then WRITE). Address arithmetic wraps modulo 2^ADDR_WIDTH.
// Optional feature macro: MEM_COPY_FILL_EN adds fill/fillValue inputs; with
// fill=1 the engine skips READ and writes fillValue at one word per cycle.
// dbgState exposes the FSM state (mem_copy_pkg encoding) for observation.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = mem_copy_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_copy_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddr,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic [ADDR_WIDTH-1:0] length,
`ifdef MEM_COPY_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fillValue,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbgState,
  mem_copy_engine_if.master     memBus
);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] remaining;

`ifdef MEM_COPY_FILL_EN
  logic                  fillMode;
  logic [DATA_WIDTH-1:0] fillData;
`endif

  // The write after the last word goes to DONE; otherwise back to READ (or
  // straight to another WRITE when filling).
  logic lastWord;
  assign lastWord = (remaining == ADDR_WIDTH'(1));

  // FSM and the src/dst/remaining counters; reset aborts any copy at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
`ifdef MEM_COPY_FILL_EN
      fillMode  <= 1'b0;
      fillData  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src       <= srcAddr;
            dst       <= dstAddr;
            remaining <= length;
`ifdef MEM_COPY_FILL_EN
            fillMode  <= fill;
            fillData  <= fillValue;
            if (length == '0)  state <= DONE;
            else if (fill)     state <= WRITE;
            else               state <= READ;
`else
            state     <= (length == '0) ? DONE : READ;
`endif
          end
        end
        READ: begin
          state <= WRITE;
        end
        WRITE: begin
          src       <= src + ADDR_WIDTH'(1);
          dst       <= dst + ADDR_WIDTH'(1);
          remaining <= remaining - ADDR_WIDTH'(1);
`ifdef MEM_COPY_FILL_EN
          if (lastWord)      state <= DONE;
          else if (fillMode) state <= WRITE;
          else               state <= READ;
`else
          state <= lastWord ? DONE : READ;
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port drive decoded from state; write data is the memory's read
  // data passed straight through (or the captured fill word).
  always_comb begin
    memBus.memAddress     = '0;
    memBus.memDataIn      = '0;
    memBus.memWriteEnable = 1'b0;
    case (state)
      READ: begin
        memBus.memAddress = src;
      end
      WRITE: begin
        memBus.memAddress     = dst;
        memBus.memWriteEnable = 1'b1;
`ifdef MEM_COPY_FILL_EN
        memBus.memDataIn      = fillMode ? fillData : memBus.memDataOut;
`else
        memBus.memDataIn      = memBus.memDataOut;
`endif
      end
      default: begin
        memBus.memAddress = '0;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dbgState = state;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural single-port memory with registered
// read, write monitor feeding an observed queue, expected writes queued by
// each scenario task and compared after the copy completes.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] srcAddr = '0;
  logic [AW-1:0] dstAddr = '0;
  logic [AW-1:0] length = '0;
`ifdef MEM_COPY_FILL_EN
  logic          fill = 1'b0;
  logic [DW-1:0] fillValue = '0;
`endif
  logic          busy;
  logic          done;
  logic [1:0]    dbgState;

  mem_copy_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .start    (start),
    .srcAddr  (srcAddr),
    .dstAddr  (dstAddr),
    .length   (length),
`ifdef MEM_COPY_FILL_EN
    .fill     (fill),
    .fillValue(fillValue),
`endif
    .busy     (busy),
    .done     (done),
    .dbgState (dbgState),
    .memBus   (bus)
  );

  // clock
  always #5 clk = ~clk;

  // memory model: preload port has priority, registered read
  logic [DW-1:0] mem [0:65535];
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeAddr = '0;
  logic [DW-1:0] pokeData = '0;

  always @(posedge clk) begin
    if (pokeEn) mem[pokeAddr] <= pokeData;
    else if (bus.memWriteEnable) mem[bus.memAddress] <= bus.memDataIn;
    bus.memDataOut <= mem[bus.memAddress];
  end

  // scoreboard queues and observation counters
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int readCycles = 0;
  int nCmp = 0;
  int nErr = 0;

  always @(posedge clk) begin
    if (bus.memWriteEnable) obs_q.push_back({bus.memAddress, bus.memDataIn});
    if (dbgState == READ) readCycles <= readCycles + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // Raises start for one cycle; returns at the first negedge after the accept edge.
  task automatic startCopy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] l, input bit f, input logic [DW-1:0] fv);
    @(negedge clk);
    start = 1'b1; srcAddr = s; dstAddr = d; length = l;
`ifdef MEM_COPY_FILL_EN
    fill = f; fillValue = fv;
`else
    if (f || fv != '0) $display("note: fill ignored in copy-only build");
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from start to the first negedge with done high (1 = cycle after accept).
  task automatic waitDone(output int cycles, output bit timedOut);
    cycles = 1;
    timedOut = 1'b0;
    while (!done) begin
      if (cycles > 300) begin
        timedOut = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk);
    nCmp++;
    if ({busy, done, bus.memWriteEnable, bus.memAddress, bus.memDataIn, dbgState} !==
        {1'b0, 1'b0, 1'b0, 16'h0, 16'h0, IDLE}) begin
      nErr++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b addr=%h din=%h st=%0d required all zero/IDLE",
               busy, done, bus.memWriteEnable, bus.memAddress, bus.memDataIn, dbgState);
    end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_copy;
    int cyc; bit to; logic [31:0] e, o;
    logic [DW-1:0] vals [4];
    vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300; vals[3] = 16'd400;
    for (int i = 0; i < 4; i++) begin
      poke(AW'(i), vals[i]);
      poke(AW'(16 + i), 16'h0);
    end
    obs_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({16'(16'h0010 + i), vals[i]});
    startCopy(16'h0000, 16'h0010, 16'd4, 1'b0, '0);
    nCmp++;
    if (dbgState !== READ) begin
      nErr++; $display("FAIL basic_first_state: got %0d required %0d", dbgState, READ);
    end
    waitDone(cyc, to);
    nCmp++;
    if (to || cyc != 9) begin
      nErr++; $display("FAIL basic_latency: got %0d (timeout=%0b) required 9", cyc, to);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      nCmp++;
      if (o !== e) begin nErr++; $display("FAIL basic_write: got %h required %h", o, e); end
    end
    nCmp++;
    if (obs_q.size() != 0) begin
      nErr++; $display("FAIL basic_extra_writes: got %0d required 0", obs_q.size());
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      nCmp++;
      if (mem[16 + i] !== vals[i]) begin
        nErr++; $display("FAIL basic_mem[%0d]: got %0d required %0d", 16 + i, mem[16 + i], vals[i]);
      end
    end
    nCmp++;
    if (busy !== 1'b0 || dbgState !== IDLE) begin
      nErr++; $display("FAIL basic_busy_after: busy=%b st=%0d required 0/IDLE", busy, dbgState);
    end
  endtask

  task automatic test_zero_length;
    int cyc; bit to;
    poke(16'd5, 16'h1234);
    poke(16'd6, 16'h5678);
    obs_q.delete();
    startCopy(16'd5, 16'd6, 16'd0, 1'b0, '0);
    waitDone(cyc, to);
    nCmp++;
    if (to || cyc != 1) begin
      nErr++; $display("FAIL zero_latency: got %0d (timeout=%0b) required 1", cyc, to);
    end
    @(negedge clk);
    nCmp++;
    if (obs_q.size() != 0) begin
      nErr++; $display("FAIL zero_writes: got %0d required 0", obs_q.size());
    end
    nCmp++;
    if (mem[6] !== 16'h5678) begin
      nErr++; $display("FAIL zero_mem6: got %h required 5678", mem[6]);
    end
  endtask

  task automatic test_wrap;
    int cyc; bit to; logic [31:0] e, o;
    poke(16'hFFFF, 16'd7);
    poke(16'h0000, 16'd9);
    poke(16'h0020, 16'h0);
    poke(16'h0021, 16'h0);
    obs_q.delete();
    exp_q.push_back({16'h0020, 16'd7});
    exp_q.push_back({16'h0021, 16'd9});
    startCopy(16'hFFFF, 16'h0020, 16'd2, 1'b0, '0);
    waitDone(cyc, to);
    nCmp++;
    if (to || cyc != 5) begin
      nErr++; $display("FAIL wrap_latency: got %0d (timeout=%0b) required 5", cyc, to);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      nCmp++;
      if (o !== e) begin nErr++; $display("FAIL wrap_write: got %h required %h", o, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_overlap;
    int cyc; bit to; logic [31:0] e, o;
    poke(16'd0, 16'd1);
    poke(16'd1, 16'd2);
    poke(16'd2, 16'd3);
    poke(16'd3, 16'd0);
    obs_q.delete();
    for (int i = 1; i <= 3; i++) exp_q.push_back({16'(i), 16'd1});
    startCopy(16'd0, 16'd1, 16'd3, 1'b0, '0);
    waitDone(cyc, to);
    nCmp++;
    if (to || cyc != 7) begin
      nErr++; $display("FAIL overlap_latency: got %0d (timeout=%0b) required 7", cyc, to);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      nCmp++;
      if (o !== e) begin nErr++; $display("FAIL overlap_write: got %h required %h", o, e); end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      nCmp++;
      if (mem[i] !== 16'd1) begin
        nErr++; $display("FAIL overlap_mem[%0d]: got %0d required 1", i, mem[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int cyc; logic [31:0] e, o;
    logic [DW-1:0] vals [3];
    vals[0] = 16'd11; vals[1] = 16'd22; vals[2] = 16'd33;
    for (int i = 0; i < 3; i++) poke(AW'(16'h0040 + i), vals[i]);
    poke(16'h0090, 16'h5555);
    obs_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({16'(16'h0050 + i), vals[i]});
    startCopy(16'h0040, 16'h0050, 16'd3, 1'b0, '0);
    cyc = 1;
    while (!done && cyc <= 300) begin
      if (cyc == 2 || cyc == 4) begin
        start = 1'b1; srcAddr = 16'h0041; dstAddr = 16'h0090; length = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    nCmp++;
    if (cyc != 7) begin
      nErr++; $display("FAIL ignored_latency: got %0d required 7", cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      nCmp++;
      if (o !== e) begin nErr++; $display("FAIL ignored_write: got %h required %h", o, e); end
    end
    @(negedge clk);
    nCmp++;
    if (obs_q.size() != 0 || mem[16'h0090] !== 16'h5555 || dbgState !== IDLE) begin
      nErr++; $display("FAIL ignored_side_effect: extra=%0d mem90=%h st=%0d required 0/5555/IDLE",
                       obs_q.size(), mem[16'h0090], dbgState);
    end
  endtask

  task automatic test_reset_mid_copy;
    logic [31:0] e, o;
    for (int i = 0; i < 4; i++) begin
      poke(AW'(16'h0060 + i), 16'(16'hA000 + i));
      poke(AW'(16'h0070 + i), 16'hEEEE);
    end
    obs_q.delete();
    exp_q.push_back({16'h0070, 16'hA000});
    exp_q.push_back({16'h0071, 16'hA001});
    startCopy(16'h0060, 16'h0070, 16'd4, 1'b0, '0);
    repeat (4) @(negedge clk);
    resetN = 1'b0;
    #1;
    nCmp++;
    if ({busy, done, bus.memWriteEnable, bus.memAddress, bus.memDataIn, dbgState} !==
        {1'b0, 1'b0, 1'b0, 16'h0, 16'h0, IDLE}) begin
      nErr++;
      $display("FAIL midreset_outputs: busy=%b done=%b we=%b addr=%h din=%h st=%0d required all zero/IDLE",
               busy, done, bus.memWriteEnable, bus.memAddress, bus.memDataIn, dbgState);
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      nCmp++;
      if (o !== e) begin nErr++; $display("FAIL midreset_write: got %h required %h", o, e); end
    end
    nCmp++;
    if (obs_q.size() != 0 || mem[16'h0072] !== 16'hEEEE || mem[16'h0073] !== 16'hEEEE) begin
      nErr++; $display("FAIL midreset_untouched: extra=%0d mem72=%h mem73=%h required 0/EEEE/EEEE",
                       obs_q.size(), mem[16'h0072], mem[16'h0073]);
    end
    nCmp++;
    if (busy !== 1'b0) begin
      nErr++; $display("FAIL midreset_idle_after: busy=%b required 0", busy);
    end
  endtask

`ifdef MEM_COPY_FILL_EN
  task automatic test_fill;
    int cyc; bit to; int readsBefore; logic [31:0] e, o;
    for (int i = 0; i < 3; i++) poke(AW'(8 + i), 16'h0);
    obs_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({16'(8 + i), 16'hABCD});
    readsBefore = readCycles;
    startCopy(16'h1234, 16'd8, 16'd3, 1'b1, 16'hABCD);
    waitDone(cyc, to);
    fill = 1'b0;
    nCmp++;
    if (to || cyc != 4) begin
      nErr++; $display("FAIL fill_latency: got %0d (timeout=%0b) required 4", cyc, to);
    end
    nCmp++;
    if (readCycles != readsBefore) begin
      nErr++; $display("FAIL fill_read_cycles: got %0d required 0", readCycles - readsBefore);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      nCmp++;
      if (o !== e) begin nErr++; $display("FAIL fill_write: got %h required %h", o, e); end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_overlap();
    test_ignored_start();
    test_reset_mid_copy();
`ifdef MEM_COPY_FILL_EN
    test_fill();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
